// File: rtl/chan_slot_router.sv
// slot_fifo: show-ahead byte FIFO, 2**DEPTH_LOG2 entries, wrap-bit pointers.
// Latency: a pushed byte appears at dout (and in count) the cycle after the push.
// Backpressure: push on full only lands with a same-cycle pop; pop on empty is ignored.
// Ports: clk/reset (sync, active-low), push/din in, pop in, dout = head, count = 0..depth.
module slot_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                empty;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    // Extra wrap bit separates full from empty when the index bits match.
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
endmodule

// chan_slot_router: routes the FX2 channel pipe to NUM_SLOTS slot byte streams plus one STAT channel.
// Latency: 1 cycle host byte -> slot_out_valid and slot_in byte -> f2hValid; channel decode is combinational.
// Backpressure: h2fReady follows the selected h2f FIFO (full-with-pop still accepts); slot_in_ready = f2h not full.
// Ports: clk_fx2/reset (sync, active-low); chanAddr/h2f*/f2h* host side; slot_out_* and slot_in_* slot side,
//        slot k on data bits [8k+7:8k] and flag bit k.
module chan_slot_router #(
    parameter int NUM_SLOTS  = 4,
    parameter int CHAN_BASE  = 0,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk_fx2,
    input  logic                   reset,
    input  logic [6:0]             chanAddr,
    input  logic [7:0]             h2fData,
    input  logic                   h2fValid,
    output logic                   h2fReady,
    output logic [7:0]             f2hData,
    output logic                   f2hValid,
    input  logic                   f2hReady,
    output logic [8*NUM_SLOTS-1:0] slot_out_data,
    output logic [NUM_SLOTS-1:0]   slot_out_valid,
    input  logic [NUM_SLOTS-1:0]   slot_out_ready,
    input  logic [8*NUM_SLOTS-1:0] slot_in_data,
    input  logic [NUM_SLOTS-1:0]   slot_in_valid,
    output logic [NUM_SLOTS-1:0]   slot_in_ready
);
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Unsigned 9-bit difference: channels below CHAN_BASE wrap far above 8,
    // so they can never alias a slot or STAT index.
    logic [8:0]           sel;
    logic [NUM_SLOTS-1:0] hit;
    logic                 is_slot;
    logic                 is_stat;

    logic [NUM_SLOTS-1:0] h2f_empty, h2f_full, h2f_pop, h2f_push;
    logic [NUM_SLOTS-1:0] f2h_empty, f2h_full, f2h_pop;
    logic [CW-1:0]        h2f_cnt [NUM_SLOTS];
    logic [CW-1:0]        f2h_cnt [NUM_SLOTS];
    logic [7:0]           f2h_head [NUM_SLOTS];

    logic                 h2f_room;
    logic                 f2h_any;
    logic [7:0]           f2h_head_sel;
    logic [CW-1:0]        stat_cnt;
    logic [5:0]           stat_cnt6;

    logic [2:0]           stat_sel;
    logic                 drop_err;
    logic                 ovf_any;

    assign sel     = {2'b00, chanAddr} - 9'(CHAN_BASE);
    assign is_slot = |hit;
    assign is_stat = (sel == 9'(NUM_SLOTS));

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
            assign hit[k]       = (sel == 9'(k));
            assign h2f_empty[k] = (h2f_cnt[k] == '0);
            assign h2f_full[k]  = (h2f_cnt[k] == CW'(DEPTH));
            assign f2h_empty[k] = (f2h_cnt[k] == '0);
            assign f2h_full[k]  = (f2h_cnt[k] == CW'(DEPTH));
            assign h2f_pop[k]   = slot_out_ready[k] & ~h2f_empty[k];
            assign h2f_push[k]  = hit[k] & h2fValid & h2fReady;
            assign f2h_pop[k]   = hit[k] & f2hReady & ~f2h_empty[k];

            slot_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_h2f (
                .clk   (clk_fx2),
                .reset (reset),
                .push  (h2f_push[k]),
                .pop   (h2f_pop[k]),
                .din   (h2fData),
                .dout  (slot_out_data[8*k +: 8]),
                .count (h2f_cnt[k])
            );

            // Push is offered unconditionally; the FIFO drops it when full and not popped.
            slot_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_f2h (
                .clk   (clk_fx2),
                .reset (reset),
                .push  (slot_in_valid[k]),
                .pop   (f2h_pop[k]),
                .din   (slot_in_data[8*k +: 8]),
                .dout  (f2h_head[k]),
                .count (f2h_cnt[k])
            );
        end
    endgenerate

    assign slot_out_valid = {NUM_SLOTS{reset}} & ~h2f_empty;
    assign slot_in_ready  = {NUM_SLOTS{reset}} & ~f2h_full;

    // Mux the selected slot's FIFO state and the STAT-selected h2f level.
    always_comb begin
        h2f_room     = 1'b0;
        f2h_any      = 1'b0;
        f2h_head_sel = 8'h00;
        stat_cnt     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit[i]) begin
                h2f_room     = ~h2f_full[i] | h2f_pop[i];
                f2h_any      = ~f2h_empty[i];
                f2h_head_sel = f2h_head[i];
            end
            if (stat_sel == 3'(i)) stat_cnt = h2f_cnt[i];
        end
        stat_cnt6 = (32'(stat_cnt) > 32'd63) ? 6'd63 : 6'(stat_cnt);
    end

    // Ready/valid never depend on the opposite handshake input of the same direction.
    always_comb begin
        h2fReady = 1'b0;
        f2hValid = 1'b0;
        f2hData  = 8'h00;
        if (reset) begin
            if (is_slot) begin
                h2fReady = h2f_room;
                f2hValid = f2h_any;
                f2hData  = f2h_head_sel;
            end else if (is_stat) begin
                h2fReady = 1'b1;
                f2hValid = 1'b1;
                f2hData  = {drop_err, ovf_any, stat_cnt6};
            end else begin
                h2fReady = 1'b1;
                f2hValid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fx2) begin
        if (!reset) begin
            stat_sel <= 3'd0;
            drop_err <= 1'b0;
            ovf_any  <= 1'b0;
        end else begin
            if (is_stat && h2fValid) begin
                if (h2fData < 8'(NUM_SLOTS)) stat_sel <= h2fData[2:0];
                if (h2fData == 8'hFF) begin
                    drop_err <= 1'b0;
                    ovf_any  <= 1'b0;
                end
            end
            if (!is_slot && !is_stat && h2fValid) drop_err <= 1'b1;
            // Set after clear so a same-cycle event is never lost.
            if (|(slot_in_valid & f2h_full & ~f2h_pop)) ovf_any <= 1'b1;
        end
    end
endmodule
